io_stream_loader: RTL and testbench

//   Upstream feeder for the IO-module two-read-port RAM. Accepts a valid/ready stream of
//   IN_WIDTH-bit beats from the input interface and packs pairs of beats into DATA_WIDTH-bit

---
 rtl/io_pkg.sv | 15 +
 rtl/io_stream_loader.sv | 127 ++++++++++++
 tb/tb_io_stream_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared defaults and FSM state type for the IO-module loader, RAM and top level.
package io_pkg;
  localparam int unsigned DEF_IN_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH    = 64;
  localparam int unsigned DEF_ADDRESS_WIDTH = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR,
    S_DRAIN,
    S_FIN
  } loader_state_t;
endpackage

// File: rtl/io_stream_loader.sv
// Packs pairs of valid/ready input beats into RAM words and writes them to
// consecutive addresses from BASE_ADDR; pulses done when the load ends.
module io_stream_loader
  import io_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned IN_WIDTH      = DEF_IN_WIDTH,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned BASE_ADDR     = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WIDTH-1:0]      in_data,
  input  logic                     in_last,
  output logic                     WR_Enable,
  output logic [ADDRESS_WIDTH-1:0] address_WR,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] word_count,
  output logic                     overflow
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_ADDR = ADDRESS_WIDTH'(BASE_ADDR);

  loader_state_t              state;
  logic [ADDRESS_WIDTH-1:0]   addr;
  logic [IN_WIDTH-1:0]        lo;
  logic                       last_pend;
  logic                       xfer;

  assign xfer = in_valid & in_ready;

  // dataIn is loaded directly on the completing beat, so it doubles as the hi register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      addr       <= '0;
      lo         <= '0;
      last_pend  <= 1'b0;
      in_ready   <= 1'b0;
      WR_Enable  <= 1'b0;
      address_WR <= '0;
      dataIn     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr       <= FIRST_ADDR;
            word_count <= '0;
            overflow   <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            state      <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            lo <= in_data;
            if (in_last) begin
              last_pend  <= 1'b1;
              in_ready   <= 1'b0;
              WR_Enable  <= 1'b1;
              address_WR <= addr;
              dataIn     <= {IN_WIDTH'(0), in_data};
              state      <= S_WR;
            end else begin
              last_pend <= 1'b0;
              state     <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            last_pend  <= in_last;
            in_ready   <= 1'b0;
            WR_Enable  <= 1'b1;
            address_WR <= addr;
            dataIn     <= {in_data, lo};
            state      <= S_WR;
          end
        end
        S_WR: begin
          WR_Enable  <= 1'b0;
          word_count <= word_count + ADDRESS_WIDTH'(1);
          if (last_pend) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else if (addr == LAST_ADDR) begin
            in_ready <= 1'b1;
            state    <= S_DRAIN;
          end else begin
            addr     <= addr + ADDRESS_WIDTH'(1);
            in_ready <= 1'b1;
            state    <= S_LO;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            overflow <= 1'b1;
            if (in_last) begin
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_stream_loader.sv
// Directed bench for io_stream_loader: packing, odd counts, gaps, overflow and reset.
module tb_io_stream_loader;
  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          WR_Enable;
  logic [AW-1:0] address_WR;
  logic [DW-1:0] dataIn;
  logic          busy;
  logic          done;
  logic [AW-1:0] word_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            done_count = 0;
  int            width_err = 0;
  logic          prev_we = 1'b0;
  logic [IW-1:0] beats[0:63];

  io_stream_loader #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .IN_WIDTH(IW),
    .DEPTH(DEPTH),
    .BASE_ADDR(0)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .WR_Enable(WR_Enable), .address_WR(address_WR), .dataIn(dataIn),
    .busy(busy), .done(done), .word_count(word_count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // RAM write log, sampled away from the active edge
  always @(negedge CLK) begin
    if (WR_Enable) begin
      wr_addr_q.push_back(address_WR);
      wr_data_q.push_back(dataIn);
      if (prev_we) width_err++;
    end
    if (done) done_count++;
    prev_we = WR_Enable;
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic l, input int gap);
    bit ok = 0;
    repeat (gap) @(negedge CLK);
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge CLK);
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1; break; end
      @(negedge CLK);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done=%0b required 1 within 300 cycles", done);
    end
    @(negedge CLK);
  endtask

  task automatic run_load(input int n, input int max_gap);
    do_start();
    for (int i = 0; i < n; i++)
      send_beat(beats[i], (i == n - 1), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    wait_done();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #13;
    checks++;
    if ({in_ready, WR_Enable, busy, done, overflow} !== 5'b0 || address_WR !== '0 ||
        dataIn !== '0 || word_count !== '0) begin
      errors++;
      $display("FAIL reset_hold: ready=%0b we=%0b busy=%0b done=%0b ovf=%0b addr=%0h data=%0h wc=%0d required all 0",
               in_ready, WR_Enable, busy, done, overflow, address_WR, dataIn, word_count);
    end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || word_count !== '0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b busy=%0b wc=%0d required 0 0 0", in_ready, busy, word_count);
    end
  endtask

  task automatic test_basic(input int max_gap, input string tag);
    int b = wr_addr_q.size();
    int d0 = done_count;
    int w0 = width_err;
    beats[0] = 32'h11111111; beats[1] = 32'h22222222;
    beats[2] = 32'h33333333; beats[3] = 32'h44444444;
    do_start();
    send_beat(beats[0], 1'b0, max_gap ? $urandom_range(0, max_gap) : 0);
    send_beat(beats[1], 1'b0, max_gap ? $urandom_range(0, max_gap) : 0);
    do_start();  // must be ignored while busy
    send_beat(beats[2], 1'b0, max_gap ? $urandom_range(0, max_gap) : 0);
    send_beat(beats[3], 1'b1, max_gap ? $urandom_range(0, max_gap) : 0);
    wait_done();
    @(negedge CLK);
    checks++;
    if (wr_addr_q.size() - b !== 2) begin
      errors++;
      $display("FAIL %s_writes: got %0d required 2", tag, wr_addr_q.size() - b);
    end else begin
      checks++;
      if (wr_addr_q[b] !== 13'd0 || wr_data_q[b] !== 64'h2222222211111111) begin
        errors++;
        $display("FAIL %s_word0: addr=%0d data=%h required 0 2222222211111111", tag, wr_addr_q[b], wr_data_q[b]);
      end
      checks++;
      if (wr_addr_q[b+1] !== 13'd1 || wr_data_q[b+1] !== 64'h4444444433333333) begin
        errors++;
        $display("FAIL %s_word1: addr=%0d data=%h required 1 4444444433333333", tag, wr_addr_q[b+1], wr_data_q[b+1]);
      end
    end
    checks++;
    if (word_count !== 13'd2 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: wc=%0d ovf=%0b busy=%0b required 2 0 0", tag, word_count, overflow, busy);
    end
    checks++;
    if (done_count - d0 !== 1 || width_err !== w0) begin
      errors++;
      $display("FAIL %s_pulses: done=%0d width_err=%0d required 1 0", tag, done_count - d0, width_err - w0);
    end
  endtask

  task automatic test_odd();
    int b = wr_addr_q.size();
    beats[0] = 32'hAAAA0001; beats[1] = 32'hAAAA0002; beats[2] = 32'hAAAA0003;
    run_load(3, 0);
    checks++;
    if (wr_addr_q.size() - b !== 2) begin
      errors++;
      $display("FAIL odd_writes: got %0d required 2", wr_addr_q.size() - b);
    end else begin
      checks++;
      if (wr_data_q[b] !== 64'hAAAA0002AAAA0001) begin
        errors++;
        $display("FAIL odd_word0: data=%h required aaaa0002aaaa0001", wr_data_q[b]);
      end
      checks++;
      if (wr_addr_q[b+1] !== 13'd1 || wr_data_q[b+1] !== 64'h00000000AAAA0003) begin
        errors++;
        $display("FAIL odd_word1: addr=%0d data=%h required 1 00000000aaaa0003", wr_addr_q[b+1], wr_data_q[b+1]);
      end
    end
    checks++;
    if (word_count !== 13'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL odd_status: wc=%0d ovf=%0b required 2 0", word_count, overflow);
    end
  endtask

  task automatic test_fill(input int n, input string tag);
    int b = wr_addr_q.size();
    int d0 = done_count;
    logic exp_ovf = (n > 2 * DEPTH);
    for (int i = 0; i < n; i++) beats[i] = 32'(i + 1);
    run_load(n, 0);
    checks++;
    if (wr_addr_q.size() - b !== DEPTH) begin
      errors++;
      $display("FAIL %s_writes: got %0d required %0d", tag, wr_addr_q.size() - b, DEPTH);
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        checks++;
        if (wr_addr_q[b+k] !== AW'(k) || wr_data_q[b+k] !== {32'(2*k+2), 32'(2*k+1)}) begin
          errors++;
          $display("FAIL %s_word%0d: addr=%0d data=%h required %0d %h", tag, k, wr_addr_q[b+k],
                   wr_data_q[b+k], k, {32'(2*k+2), 32'(2*k+1)});
        end
      end
    end
    checks++;
    if (word_count !== AW'(DEPTH) || overflow !== exp_ovf || done_count - d0 !== 1) begin
      errors++;
      $display("FAIL %s_status: wc=%0d ovf=%0b done=%0d required %0d %0b 1", tag, word_count,
               overflow, done_count - d0, DEPTH, exp_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int b = wr_addr_q.size();
    do_start();
    send_beat(32'h55555555, 1'b0, 0);
    #2 RST = 1'b0;
    #10;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (wr_addr_q.size() !== b || busy !== 1'b0 || word_count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: writes=%0d busy=%0b wc=%0d ovf=%0b required 0 0 0 0",
               wr_addr_q.size() - b, busy, word_count, overflow);
    end
    test_basic(0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_odd();
    test_basic(3, "gapped");
    test_fill(34, "overflow");
    test_fill(32, "exact");
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
